agc_timepulse_gen: RTL and testbench
====================================

# agc_timepulse_gen

Timepulse generator for the gate-level AGC core: divides SIM_CLK into phase ticks and emits the one-hot T01–T12 timepulse train, PHS2/PHS4 phase strobes and an end-of-memory-cycle strobe. It sits directly upstream of the NOR-gate network, whose gates sample on the falling SIM_CLK edge and apply a one-cycle glitch filter. All outputs are therefore registered on the rising edge and held stable for at least two SIM_CLK cycles. Run, stop and single-step control come from the monitor/DSKY interface.

## Interface
- DIV, 4, SIM_CLK cycles per phase; legal range 2–255. Values below 2 violate the gate glitch filter.
- SIM_CLK  in  1  simulation clock; all state updates on posedge.
- SIM_RST  in  1  reset, asynchronous, active-high.
- RUN  in  1  level; 1 = free-running MCTs.
- STEP  in  1  single-MCT request; rising edge detected internally.
- T  out  12  one-hot timepulse; bit 0 = T01, bit 11 = T12; all-zero when idle.
- PHS2  out  1  high during phase 2 of every timepulse.
- PHS4  out  1  high during phase 4 of every timepulse.
- MCT_END  out  1  one-cycle strobe on the last SIM_CLK cycle of T12 phase 4.
- MCT_CNT  out  16  completed-MCT count; wraps from 0xFFFF to 0x0000.
- BUSY  out  1  high in RUN or STEP state.

## Operation
- Counters:
  - div_cnt 0..DIV-1
  - ph 1..4, advances when div_cnt = DIV-1
  - tp 1..12, advances when ph = 4 and div_cnt = DIV-1
  - tp wraps 12 -> 1
- States:
  - IDLE: counters held at tp=1, ph=1, div_cnt=0. T=0, PHS2=PHS4=0.
  - RUN: continuous MCTs.
  - STEP: exactly one MCT.
- Transitions:
  - IDLE -> RUN: RUN=1 at posedge.
  - IDLE -> STEP: STEP rising edge with RUN=0. RUN=1 has priority when both occur.
  - RUN -> IDLE: at MCT end if RUN=0 at that edge. An MCT is never truncated; RUN dropping mid-MCT has no effect until T12 phase 4 completes.
  - RUN -> RUN: at MCT end if RUN=1.
  - STEP -> RUN: at MCT end if RUN=1.
  - STEP -> IDLE: at MCT end otherwise.
- STEP edges arriving in RUN or STEP are ignored and not queued.
- STEP edge detection: STEP is registered once, and edge = STEP & ~STEP_q. STEP_q resets to 0; STEP held high through reset therefore yields one edge after release.
- Outputs in RUN/STEP:
  - T[tp-1]=1
  - PHS2 = (ph==2)
  - PHS4 = (ph==4)
- MCT_END asserts while tp=12, ph=4, div_cnt=DIV-1 in RUN/STEP. MCT_CNT increments on that same edge.
- Reset values: T=0, PHS2=0, PHS4=0, MCT_END=0, MCT_CNT=0, BUSY=0, state IDLE, STEP_q=0.
- Reset mid-MCT clears all outputs immediately, without waiting for a clock. No partial MCT resumes.

## Timing
- All outputs are registered; they change only on posedge SIM_CLK, or asynchronously on SIM_RST assertion.
- Start latency: RUN=1 sampled at posedge k in IDLE. T01, BUSY and phase 1 are visible after posedge k+1. STEP start has one extra cycle for edge registration.
- Phase duration: DIV cycles. Timepulse: 4·DIV cycles. MCT: 48·DIV cycles (192 at DIV=4).
- In back-to-back MCTs, T12 -> T01 has no gap cycle.
- Stop: after the MCT_END cycle, T=0 and BUSY=0 on the following posedge.
- Reset release is synchronous to the first posedge after SIM_RST falls; no output changes before it.

## Configuration
- AGC_TPGEN_STEP_EN defined: the STEP input, edge detector and STEP state are present as described.
- AGC_TPGEN_STEP_EN undefined:
  - The STEP port still exists but is ignored.
  - The STEP state and STEP_q are removed.
  - Only RUN controls the generator.

## Test plan
- Reset/idle, DIV=4, SIM_RST pulsed mid-T05 with RUN=1 -> T=0, PHS2=0, MCT_CNT=0 within the same cycle. Deassert with RUN=1 -> T01 after the second posedge.
- Free run, DIV=4, RUN=1 for 3 MCTs:
  - each T bit high exactly 16 cycles
  - PHS2 high 4 of every 16
  - MCT_END pulses at cycles 192, 384, 576 after start
  - MCT_CNT=3
- Stop mid-MCT: RUN dropped during T06 -> pulses continue through T12 ph4. BUSY=0 and T=0 one cycle after MCT_END; MCT_CNT incremented once.
- Single step (macro on), DIV=2, STEP pulsed -> exactly one MCT of 96 cycles, then IDLE. A second STEP edge during that MCT is ignored, so MCT_CNT=1.
- Step-to-run: STEP pulse, then RUN=1 during T08 -> continues into the next MCT with no gap; state RUN.
- Wrap/minimum DIV: DIV=2, MCT_CNT preloaded via force to 0xFFFF, one MCT -> MCT_CNT=0x0000. Every output level lasts ≥2 cycles.

Source files
------------

// File: rtl/agc_timepulse_gen.sv
// rtl/agc_timepulse_gen.sv - AGC T01-T12 timepulse, phase strobe and MCT-end generator
// Single-step mode is compiled in only when AGC_TPGEN_STEP_EN is defined.
module agc_timepulse_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        RUN,
    input  logic        STEP,
    output logic [11:0] T,
    output logic        PHS2,
    output logic        PHS4,
    output logic        MCT_END,
    output logic [15:0] MCT_CNT,
    output logic        BUSY
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [2:0]  ph_q, ph_d;
    logic [3:0]  tp_q, tp_d;
    logic [15:0] mct_cnt_q, mct_cnt_d;
    logic [11:0] t_q, t_d;
    logic        phs2_q, phs2_d;
    logic        phs4_q, phs4_d;
    logic        mct_end_q, mct_end_d;
    logic        busy_q, busy_d;

    logic active, div_wrap, ph_wrap, mct_end;

    assign active   = (state_q != S_IDLE);
    assign div_wrap = (div_cnt_q == DIV_LAST);
    assign ph_wrap  = div_wrap && (ph_q == 3'd4);
    assign mct_end  = active && ph_wrap && (tp_q == 4'd12);

`ifdef AGC_TPGEN_STEP_EN
    // The edge itself is registered, giving STEP starts one cycle more latency than RUN.
    logic step_q, step_d, step_edge_q, step_edge_d;

    always_comb begin
        step_d      = STEP;
        step_edge_d = STEP & ~step_q;
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            step_q      <= 1'b0;
            step_edge_q <= 1'b0;
        end else begin
            step_q      <= step_d;
            step_edge_q <= step_edge_d;
        end
    end
`else
    logic unused_step;
    assign unused_step = STEP;
`endif

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An MCT in progress always runs to T12 phase 4 before RUN/STEP is re-evaluated.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (RUN) begin
                    state_d = S_RUN;
                end
`ifdef AGC_TPGEN_STEP_EN
                else if (step_edge_q) begin
                    state_d = S_STEP;
                end
`endif
            end
            S_RUN: begin
                if (mct_end && !RUN) begin
                    state_d = S_IDLE;
                end
            end
`ifdef AGC_TPGEN_STEP_EN
            S_STEP: begin
                if (mct_end) begin
                    state_d = RUN ? S_RUN : S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_cnt_d = 8'd0;
        ph_d      = 3'd1;
        tp_d      = 4'd1;
        mct_cnt_d = mct_cnt_q + {15'd0, mct_end};
        if (active) begin
            div_cnt_d = div_wrap ? 8'd0 : div_cnt_q + 8'd1;
            ph_d      = ph_q;
            tp_d      = tp_q;
            if (div_wrap) begin
                ph_d = (ph_q == 3'd4) ? 3'd1 : ph_q + 3'd1;
            end
            if (ph_wrap) begin
                tp_d = (tp_q == 4'd12) ? 4'd1 : tp_q + 4'd1;
            end
        end
    end

    always_comb begin
        t_d       = active ? (12'd1 << (tp_q - 4'd1)) : 12'd0;
        phs2_d    = active && (ph_q == 3'd2);
        phs4_d    = active && (ph_q == 3'd4);
        mct_end_d = mct_end;
        busy_d    = active;
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            div_cnt_q <= 8'd0;
            ph_q      <= 3'd1;
            tp_q      <= 4'd1;
            mct_cnt_q <= 16'd0;
            t_q       <= 12'd0;
            phs2_q    <= 1'b0;
            phs4_q    <= 1'b0;
            mct_end_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ph_q      <= ph_d;
            tp_q      <= tp_d;
            mct_cnt_q <= mct_cnt_d;
            t_q       <= t_d;
            phs2_q    <= phs2_d;
            phs4_q    <= phs4_d;
            mct_end_q <= mct_end_d;
            busy_q    <= busy_d;
        end
    end

    assign T       = t_q;
    assign PHS2    = phs2_q;
    assign PHS4    = phs4_q;
    assign MCT_END = mct_end_q;
    assign MCT_CNT = mct_cnt_q;
    assign BUSY    = busy_q;
endmodule

// File: tb/tb_agc_timepulse_gen.sv
// tb/tb_agc_timepulse_gen.sv - directed bench for agc_timepulse_gen at DIV=4 and DIV=2
module tb_agc_timepulse_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run4 = 1'b0, step4 = 1'b0, run2 = 1'b0, step2 = 1'b0;
    logic [11:0] t4, t2;
    logic        phs2_4, phs4_4, mend4, busy4;
    logic        phs2_2, phs4_2, mend2, busy2;
    logic [15:0] cnt4, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    agc_timepulse_gen #(.DIV(4)) u4 (
        .SIM_CLK(clk), .SIM_RST(rst), .RUN(run4), .STEP(step4),
        .T(t4), .PHS2(phs2_4), .PHS4(phs4_4), .MCT_END(mend4), .MCT_CNT(cnt4), .BUSY(busy4)
    );

    agc_timepulse_gen #(.DIV(2)) u2 (
        .SIM_CLK(clk), .SIM_RST(rst), .RUN(run2), .STEP(step2),
        .T(t2), .PHS2(phs2_2), .PHS4(phs4_2), .MCT_END(mend2), .MCT_CNT(cnt2), .BUSY(busy2)
    );

    typedef struct {
        logic        run;
        int          ncyc;
        logic [11:0] t;
        logic        busy;
        logic        phs2;
        logic        phs4;
        logic        mend;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int bits_hi [12];
        int me_pos [3];
        int me_n, phs2_n, onehot_err, busy_err, budget, cyc, min_run, run_len, mend_n;
        logic [13:0] prev, cur;

        // run, ncyc, T, BUSY, PHS2, PHS4, MCT_END, MCT_CNT  (DIV=4, n = output cycle since T01)
        vecs[0]  = '{1'b0, 3,   12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1,   12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1,   12'h001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 4,   12'h001, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 8,   12'h001, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[5]  = '{1'b1, 4,   12'h002, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{1'b1, 100, 12'h080, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[7]  = '{1'b1, 75,  12'h800, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[8]  = '{1'b1, 1,   12'h001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[9]  = '{1'b0, 1,   12'h001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 190, 12'h800, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2};
        vecs[11] = '{1'b0, 1,   12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};

        // Reset state
        @(negedge clk);
        check("rst_T", {20'd0, t4}, 32'd0);
        check("rst_BUSY", {31'd0, busy4}, 32'd0);
        check("rst_CNT", {16'd0, cnt4}, 32'd0);
        tick(1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run4 = vecs[i].run;
            tick(vecs[i].ncyc);
            check($sformatf("v%0d_T", i),    {20'd0, t4},     {20'd0, vecs[i].t});
            check($sformatf("v%0d_BUSY", i), {31'd0, busy4},  {31'd0, vecs[i].busy});
            check($sformatf("v%0d_PHS2", i), {31'd0, phs2_4}, {31'd0, vecs[i].phs2});
            check($sformatf("v%0d_PHS4", i), {31'd0, phs4_4}, {31'd0, vecs[i].phs4});
            check($sformatf("v%0d_END", i),  {31'd0, mend4},  {31'd0, vecs[i].mend});
            check($sformatf("v%0d_CNT", i),  {16'd0, cnt4},   {16'd0, vecs[i].cnt});
        end

        // Free run for three MCTs, RUN dropped during T06 of the third
        for (int b = 0; b < 12; b++) bits_hi[b] = 0;
        me_n = 0; phs2_n = 0; onehot_err = 0; busy_err = 0;
        run4 = 1'b1;
        budget = 10;
        while (t4 == 12'd0 && budget > 0) begin tick(1); budget--; end
        check("run_start_seen", {20'd0, t4}, 32'h001);
        for (int n = 1; n <= 577; n++) begin
            if (n <= 576) begin
                for (int b = 0; b < 12; b++) if (t4[b]) bits_hi[b]++;
                if ($countones(t4) != 1) onehot_err++;
                if (!busy4) busy_err++;
                if (phs2_4) phs2_n++;
                if (mend4) begin
                    if (me_n < 3) me_pos[me_n] = n;
                    me_n++;
                end
            end else begin
                check("stop_T", {20'd0, t4}, 32'd0);
                check("stop_BUSY", {31'd0, busy4}, 32'd0);
                check("stop_CNT", {16'd0, cnt4}, 32'd5);
            end
            if (n == 470) run4 = 1'b0;
            if (n < 577) tick(1);
        end
        for (int b = 0; b < 12; b++) check($sformatf("T%0d_cycles", b + 1), bits_hi[b], 32'd48);
        check("onehot_err", onehot_err, 32'd0);
        check("busy_gap", busy_err, 32'd0);
        check("phs2_cycles", phs2_n, 32'd144);
        check("mct_end_count", me_n, 32'd3);
        check("mct_end_1", me_pos[0], 32'd192);
        check("mct_end_2", me_pos[1], 32'd384);
        check("mct_end_3", me_pos[2], 32'd576);

        // Asynchronous reset mid-T05, release with RUN held high
        run4 = 1'b1;
        budget = 200;
        while (t4 != 12'h010 && budget > 0) begin tick(1); budget--; end
        check("reach_T05", {20'd0, t4}, 32'h010);
        #2 rst = 1'b1;
        #1;
        check("arst_T", {20'd0, t4}, 32'd0);
        check("arst_PHS2", {31'd0, phs2_4}, 32'd0);
        check("arst_CNT", {16'd0, cnt4}, 32'd0);
        check("arst_BUSY", {31'd0, busy4}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("rel_edge1_T", {20'd0, t4}, 32'd0);
        tick(1);
        check("rel_edge2_T", {20'd0, t4}, 32'h001);
        check("rel_edge2_BUSY", {31'd0, busy4}, 32'd1);
        run4 = 1'b0;
        budget = 300;
        while (busy4 && budget > 0) begin tick(1); budget--; end
        check("u4_idle_after_rst_run", {31'd0, busy4}, 32'd0);

        // DIV=2 wrap of MCT_CNT and minimum output level duration
        force u2.mct_cnt_q = 16'hFFFF;
        #1 release u2.mct_cnt_q;
        tick(1);
        check("preload_CNT", {16'd0, cnt2}, 32'h0000FFFF);
        run2 = 1'b1;
        budget = 10;
        while (!busy2 && budget > 0) begin tick(1); budget--; end
        run2 = 1'b0;
        cyc = 0; mend_n = 0; min_run = 1000; run_len = 0;
        prev = {t2, phs2_2, phs4_2};
        budget = 300;
        while (busy2 && budget > 0) begin
            cur = {t2, phs2_2, phs4_2};
            if (cyc == 0 || cur == prev) run_len++;
            else begin
                if (run_len < min_run) min_run = run_len;
                run_len = 1;
            end
            prev = cur;
            if (mend2) mend_n++;
            cyc++;
            tick(1);
            budget--;
        end
        if (run_len < min_run) min_run = run_len;
        check("div2_mct_cycles", cyc, 32'd96);
        check("div2_min_level", min_run, 32'd2);
        check("div2_mct_end_n", mend_n, 32'd1);
        check("wrap_CNT", {16'd0, cnt2}, 32'd0);

`ifdef AGC_TPGEN_STEP_EN
        // Single step, with a second STEP edge mid-MCT that must be ignored
        step2 = 1'b1;
        tick(1);
        step2 = 1'b0;
        budget = 10;
        while (!busy2 && budget > 0) begin tick(1); budget--; end
        cyc = 0;
        budget = 300;
        while (busy2 && budget > 0) begin
            step2 = (cyc == 20);
            cyc++;
            tick(1);
            budget--;
        end
        step2 = 1'b0;
        check("step_mct_cycles", cyc, 32'd96);
        check("step_CNT", {16'd0, cnt2}, 32'd1);
        tick(8);
        check("step_not_queued", {31'd0, busy2}, 32'd0);

        // Step promoted to run during T08
        step2 = 1'b1;
        tick(1);
        step2 = 1'b0;
        budget = 100;
        while (t2 != 12'h080 && budget > 0) begin tick(1); budget--; end
        check("step_reach_T08", {20'd0, t2}, 32'h080);
        run2 = 1'b1;
        budget = 100;
        while (!mend2 && budget > 0) begin tick(1); budget--; end
        check("step_mct_end", {31'd0, mend2}, 32'd1);
        tick(1);
        check("step2run_T01", {20'd0, t2}, 32'h001);
        check("step2run_BUSY", {31'd0, busy2}, 32'd1);
        tick(50);
        check("step2run_still_busy", {31'd0, busy2}, 32'd1);
        run2 = 1'b0;
        budget = 200;
        while (busy2 && budget > 0) begin tick(1); budget--; end
        check("step2run_stop", {31'd0, busy2}, 32'd0);
        check("step2run_CNT", {16'd0, cnt2}, 32'd3);
`else
        // STEP has no effect without single-step support
        step2 = 1'b1;
        tick(1);
        step2 = 1'b0;
        tick(6);
        check("step_ignored_BUSY", {31'd0, busy2}, 32'd0);
        check("step_ignored_T", {20'd0, t2}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
